ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator for the team's single-port synchronous RAM: owns the RAM's clk-domain we/addr/din pins and consumes its registered dout.
- Converts a command channel (read or write, start address, burst length) into RAM accesses.
- Write beats arrive on a valid/ready write-data channel; read beats leave on a valid/ready read-data channel.
- Sits between a bus-side client (DMA, test sequencer) and one RAM instance.

Parameters:
- ADDR_WIDTH, 4, RAM address width; RAM depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.
- LEN_WIDTH, 4, burst length field width; beats = cmd_len+1, max 2**LEN_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  first beat address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- wd_valid  in  1  write beat offered.
- wd_ready  out  1  high only in WR.
- wd_data  in  DATA_WIDTH  write beat data.
- rd_valid  out  1  read beat held.
- rd_ready  in  1  consumer accepts read beat.
- rd_data  out  DATA_WIDTH  read beat data, registered.
- rd_last  out  1  marks final read beat; qualified by rd_valid.
- done  out  1  one-cycle pulse after the final beat of any burst.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_din  out  DATA_WIDTH  to RAM din.
- ram_dout  in  DATA_WIDTH  from RAM dout; 1-cycle registered read, updated only on cycles with we=0.

Behaviour:
- **Internal state:** states IDLE, WR, RD_ISSUE, RD_CAP, RD_OUT; registers cur_addr (ADDR_WIDTH) and beats_left (LEN_WIDTH).
- **Reset:** while rst is high, state=IDLE, cur_addr=0, beats_left=0, rd_data=0, rd_valid=0, done=0.
  - All derived outputs are therefore 0, except cmd_ready=1 (IDLE).
  - Asserting rst mid-burst aborts immediately: no further ram_we, no done pulse, pending read beat dropped.
- **IDLE:**
  - cmd_ready=1, ram_we=0, ram_addr=cur_addr.
  - On cmd_valid: latch cur_addr=cmd_addr and beats_left=cmd_len.
  - Go to WR if cmd_write=1, else RD_ISSUE.
- **WR:**
  - wd_ready=1; ram_we = wd_valid; ram_addr=cur_addr; ram_din=wd_data. These are combinational from state and wd_data, with no added latency.
  - On wd_valid: if beats_left=0, go to IDLE and pulse done next cycle.
  - Otherwise cur_addr+1 (mod 2**ADDR_WIDTH, wraps to 0) and beats_left-1.
  - Without wd_valid: stay, ram_we=0.
- **RD_ISSUE:** ram_we=0, ram_addr=cur_addr; go to RD_CAP. The RAM registers mem[cur_addr] at this edge.
- **RD_CAP:**
  - ram_addr held at cur_addr.
  - On the edge: rd_data<=ram_dout, rd_valid<=1, rd_last<=(beats_left==0); go to RD_OUT.
- **RD_OUT:**
  - rd_valid=1, rd_data stable; ram_addr held; ram_we=0.
  - On rd_ready: rd_valid<=0.
  - If last beat: go to IDLE and pulse done.
  - Otherwise cur_addr+1 (wrapping), beats_left-1, go to RD_ISSUE.
  - rd_data and rd_last must not change while rd_valid=1 and rd_ready=0.
- **Latency and throughput:**
  - Read: command accept at cycle t gives rd_valid at t+3; each following beat arrives 3 cycles after the previous acceptance.
  - Write: 1 beat/cycle when wd_valid is held high.
- **done:** asserted in the cycle after the final beat handshake, for exactly one cycle. It coincides with cmd_ready=1 (IDLE).
- **Simultaneous events:**
  - cmd_valid is ignored outside IDLE.
  - wd_valid is ignored outside WR; no write occurs.
  - rd_ready while rd_valid=0 has no effect.
- **Address wrap:** a burst starting at 2**ADDR_WIDTH-1 continues at 0.
- **Long bursts:** bursts longer than the RAM depth revisit addresses; later beats overwrite earlier ones.

Decomposition:
- Shared package ram_pkg holds:
  - state enum typedef (IDLE, WR, RD_ISSUE, RD_CAP, RD_OUT);
  - default width constants ADDR_WIDTH_DEF=4, DATA_WIDTH_DEF=8, LEN_WIDTH_DEF=4.
- No sub-module in the RTL itself.
- The testbench instantiates the existing single-port RAM as the responder.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=8, LEN_WIDTH=4):
- **Write burst:** cmd write addr=3 len=3, wd_data 0xA0..0xA3 on consecutive cycles → ram_we high 4 cycles at addr 3,4,5,6; done pulses once; RAM holds 0xA0..0xA3.
- **Read-back with backpressure:** cmd read addr=3 len=3 after the write burst, rd_ready held low 5 cycles on beat 1 → beats 0xA0,0xA1,0xA2,0xA3; rd_data stable while stalled; rd_last only on 0xA3; first rd_valid 3 cycles after cmd accept.
- **Address wrap:** write addr=15 len=1 with 0x11,0x22, then read addr=15 len=1 → writes hit addr 15 then 0; read returns 0x11,0x22.
- **Write-data gaps:** write len=2 with wd_valid low 2 cycles between beats → ram_we=0 during gaps; exactly 3 writes; cmd_ready=0 until done.
- **Reset mid-read:** assert rst while in RD_OUT with rd_valid=1 → rd_valid=0, cmd_ready=1, done=0 immediately; a new read afterwards starts cleanly from its own cmd_addr.
- **Command while busy:** cmd_valid asserted during a write burst → command not accepted (cmd_ready=0); accepted on the first IDLE cycle after done.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and default widths for the RAM burst master and its clients.
package ram_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAP,
    RD_OUT
  } state_e;

endpackage

// File: rtl/ram_burst_master.sv
// Turns read/write burst commands into accesses on a single-port synchronous RAM.
// Reads take three states per beat: issue address, capture registered dout, hold for consumer.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wd_valid_i,
  output logic                  wd_ready_o,
  input  logic [DATA_WIDTH-1:0] wd_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  done_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [ADDR_WIDTH-1:0] addr_inc_d;
  logic [LEN_WIDTH-1:0]  beats_left_q;
  logic [LEN_WIDTH-1:0]  beats_dec_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  done_q;

  // Address increment wraps naturally at the RAM depth.
  assign addr_inc_d  = cur_addr_q + 1'b1;
  assign beats_dec_d = beats_left_q - 1'b1;

  assign cmd_ready_o = (state_q == IDLE);
  assign wd_ready_o  = (state_q == WR);
  assign ram_we_o    = (state_q == WR) && wd_valid_i;
  assign ram_addr_o  = cur_addr_q;
  assign ram_din_o   = wd_data_i;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;
  assign done_o      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            cur_addr_q   <= cmd_addr_i;
            beats_left_q <= cmd_len_i;
            state_q      <= cmd_write_i ? WR : RD_ISSUE;
          end
        end
        WR: begin
          if (wd_valid_i) begin
            if (beats_left_q == '0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cur_addr_q   <= addr_inc_d;
              beats_left_q <= beats_dec_d;
            end
          end
        end
        RD_ISSUE: state_q <= RD_CAP;
        RD_CAP: begin
          rd_data_q  <= ram_dout_i;
          rd_valid_q <= 1'b1;
          rd_last_q  <= (beats_left_q == '0);
          state_q    <= RD_OUT;
        end
        RD_OUT: begin
          if (rd_ready_i) begin
            rd_valid_q <= 1'b0;
            if (rd_last_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cur_addr_q   <= addr_inc_d;
              beats_left_q <= beats_dec_d;
              state_q      <= RD_ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master driving a behavioural single-port RAM.
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wd_valid, wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid, rd_ready, rd_last, done;
  logic [7:0] rd_data;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [16];

  int errors = 0;
  int n_checks = 0;
  int done_cnt = 0;
  int cyc = 0;
  int acc;
  logic [11:0] wr_q [$];
  logic [8:0]  rd_q [$];
  logic [11:0] wr_exp;
  logic [8:0]  rd_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_burst_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wd_valid_i(wd_valid), .wd_ready_o(wd_ready), .wd_data_i(wd_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
    .done_o(done),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  // Single-port RAM: write when we, otherwise registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        check("wr_pending", 32'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          wr_exp = wr_q.pop_front();
          check("wr_beat", {ram_addr, ram_din}, wr_exp);
        end
      end
      if (rd_valid && rd_ready) begin
        check("rd_pending", 32'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) begin
          rd_exp = rd_q.pop_front();
          check("rd_beat", {rd_last, rd_data}, rd_exp);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [3:0] a, input logic [3:0] l, output int acc_o);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("cmd_accept", cmd_ready, 1);
    acc_o = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [7:0] base, input logic [7:0] step, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      wd_valid = 1'b1;
      wd_data  = base + 8'(i) * step;
      @(negedge clk);
      check("wd_ready", wd_ready, 1);
      check("wr_we", ram_we, 1);
      tick();
      wd_valid = 1'b0;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("gap_we", ram_we, 0);
          check("gap_cmd_ready", cmd_ready, 0);
          tick();
        end
      end
    end
    @(negedge clk);
    check("wr_done", done, 1);
    check("wr_done_idle", cmd_ready, 1);
  endtask

  task automatic recv_reads(input int n, input int stall_at, input int acc_in);
    int a;
    a = acc_in;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rd_valid) break;
      end
      check("rd_valid_seen", rd_valid, 1);
      check("rd_latency", cyc, a + 3);
      if (i == stall_at) begin
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          check("stall_valid", rd_valid, 1);
          check("stall_data", {rd_last, rd_data}, rd_q[0]);
        end
      end
      tick();
      rd_ready = 1'b1;
      @(negedge clk);
      a = cyc;
      tick();
      rd_ready = 1'b0;
    end
    @(negedge clk);
    check("rd_done", done, 1);
    check("rd_done_idle", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wd_valid = 0; wd_data = 0; rd_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wd_ready", wd_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_rd_data", rd_data, 0);
    tick();
    rst = 1'b0;

    // write burst 0xA0..0xA3 at 3..6
    for (int i = 0; i < 4; i++) wr_q.push_back({4'(3 + i), 8'(8'hA0 + i)});
    send_cmd(1'b1, 4'd3, 4'd3, acc);
    write_beats(8'hA0, 8'h01, 4, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    for (int i = 0; i < 4; i++) check("mem_a", mem[3 + i], 8'hA0 + i);

    // read back with a 5-cycle stall on beat 1
    for (int i = 0; i < 4; i++) rd_q.push_back({(i == 3), 8'(8'hA0 + i)});
    tick();
    send_cmd(1'b0, 4'd3, 4'd3, acc);
    recv_reads(4, 1, acc);

    // address wrap
    wr_q.push_back({4'd15, 8'h11});
    wr_q.push_back({4'd0, 8'h22});
    tick();
    send_cmd(1'b1, 4'd15, 4'd1, acc);
    write_beats(8'h11, 8'h11, 2, 0);
    check("mem_wrap15", mem[15], 8'h11);
    check("mem_wrap0", mem[0], 8'h22);
    rd_q.push_back({1'b0, 8'h11});
    rd_q.push_back({1'b1, 8'h22});
    tick();
    send_cmd(1'b0, 4'd15, 4'd1, acc);
    recv_reads(2, -1, acc);

    // write with gaps while a read command waits
    wr_q.push_back({4'd8, 8'h31});
    wr_q.push_back({4'd9, 8'h32});
    wr_q.push_back({4'd10, 8'h33});
    tick();
    send_cmd(1'b1, 4'd8, 4'd2, acc);
    rd_q.push_back({1'b1, 8'h31});
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd8; cmd_len = 4'd0;
    write_beats(8'h31, 8'h01, 3, 2);
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("busy_cmd_taken", cmd_ready, 0);
    recv_reads(1, -1, acc);

    // reset while a read beat is held
    tick();
    send_cmd(1'b0, 4'd4, 4'd2, acc);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_valid) break;
    end
    check("abort_rd_valid", rd_valid, 1);
    check("abort_rd_data", rd_data, 8'hA1);
    tick();
    rst = 1'b1;
    #1;
    check("abort_valid_cleared", rd_valid, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_we", ram_we, 0);
    tick();
    rst = 1'b0;
    rd_q.push_back({1'b1, 8'hA2});
    send_cmd(1'b0, 4'd5, 4'd0, acc);
    recv_reads(1, -1, acc);

    repeat (3) tick();
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("done_count", done_cnt, 7);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
